// File: rtl/muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_ctrl : iterative MULT/MULTU/DIV/DIVU unit with HI/LO and stall ctrl  |
// | Option macro: MULDIV_EARLY_OUT_EN (early finish of multiplies)             |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rd_hilo,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        is_div_q, is_div_d;
  logic        res_neg_q, res_neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic        dz_q, dz_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] mcand_q, mcand_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;

  logic        signed_op;
  logic [31:0] rs_abs, rt_abs;
  logic        can_sub;
  logic [31:0] diff;
  logic [63:0] prod;
  logic [31:0] quo, rem;
  logic        last_iter;

  always_comb begin
    signed_op = ~op[0];
    rs_abs    = (signed_op && rs_val[31]) ? 32'd0 - rs_val : rs_val;
    rt_abs    = (signed_op && rt_val[31]) ? 32'd0 - rt_val : rt_val;
    // Divide: acc holds {partial remainder, dividend/quotient} shifting left
    can_sub   = (acc_q[63:31] >= {1'b0, mplier_q});
    diff      = acc_q[62:31] - mplier_q;
    prod      = res_neg_q ? 64'd0 - acc_q : acc_q;
    quo       = res_neg_q ? 32'd0 - acc_q[31:0] : acc_q[31:0];
    rem       = rem_neg_q ? 32'd0 - acc_q[63:32] : acc_q[63:32];
`ifdef MULDIV_EARLY_OUT_EN
    last_iter = (cnt_q == 5'd31) || (!is_div_q && (mplier_q[31:1] == 31'd0));
`else
    last_iter = (cnt_q == 5'd31);
`endif

    state_d   = state_q;
    is_div_d  = is_div_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    cnt_d     = cnt_q;
    mplier_d  = mplier_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d  = op[1];
          res_neg_d = signed_op & (rs_val[31] ^ rt_val[31]);
          rem_neg_d = signed_op & rs_val[31];
          dz_d      = op[1] & (rt_val == 32'd0);
          cnt_d     = 5'd0;
          mplier_d  = rt_abs;
          mcand_d   = {32'd0, rs_abs};
          acc_d     = op[1] ? {32'd0, rs_abs} : 64'd0;
          state_d   = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 5'd1;
        if (is_div_q) begin
          acc_d = can_sub ? {diff, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = {mcand_q[62:0], 1'b0};
          mplier_d = {1'b0, mplier_q[31:1]};
        end
        if (last_iter) state_d = FIN;
      end
      FIN: begin
        if (is_div_q) begin
          // A zero divisor leaves |rs| as remainder, so the sign fix restores rs
          hi_d = rem;
          lo_d = dz_q ? 32'hFFFF_FFFF : quo;
        end else begin
          {hi_d, lo_d} = prod;
        end
        done_d  = 1'b1;
        dbz_d   = dz_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      is_div_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      cnt_q     <= 5'd0;
      mplier_q  <= 32'd0;
      mcand_q   <= 64'd0;
      acc_q     <= 64'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      cnt_q     <= cnt_d;
      mplier_q  <= mplier_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign stall       = rd_hilo & busy;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_muldiv_ctrl : directed + random checks of muldiv_ctrl against a model   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_muldiv_ctrl;
  logic        clk = 1'b0;
  logic        rst, start, rd_hilo;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, stall, done, div_by_zero;
  logic [31:0] hi, lo;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] cur_hi, cur_lo;

  muldiv_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val),
    .rt_val(rt_val), .rd_hilo(rd_hilo), .busy(busy), .stall(stall),
    .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: arithmetic results plus edges from start-accept to the done cycle
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] ehi, output logic [31:0] elo,
                                output logic edz, output int lat);
    logic [63:0] p;
    logic [31:0] babs;
    longint      sa, sb, q, r;
    int          n;
    edz = 1'b0;
    lat = 33;
    if (o[1] == 1'b0) begin
      if (o == 2'b00) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      else            p = {32'd0, a} * {32'd0, b};
      ehi = p[63:32];
      elo = p[31:0];
`ifdef MULDIV_EARLY_OUT_EN
      babs = (o == 2'b00 && b[31]) ? 32'd0 - b : b;
      n = 0;
      for (int i = 0; i < 32; i++) if (babs[i]) n = i + 1;
      if (n < 1) n = 1;
      lat = n + 1;
`else
      babs = b;
      n = 0;
`endif
    end else if (b == 32'd0) begin
      ehi = a;
      elo = 32'hFFFF_FFFF;
      edz = 1'b1;
    end else if (o == 2'b11) begin
      ehi = a % b;
      elo = a / b;
    end else begin
      sa  = $signed(a);
      sb  = $signed(b);
      q   = sa / sb;
      r   = sa % sb;
      ehi = r[31:0];
      elo = q[31:0];
    end
  endfunction

  // Issues one op at the next edge and follows it to completion.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit rd, input bit second);
    logic [31:0] ehi, elo;
    logic        edz;
    int          lat, k;
    model(o, a, b, ehi, elo, edz, lat);
    start = 1'b1; op = o; rs_val = a; rt_val = b; rd_hilo = rd;
    #1;
    chk("idle_stall", {63'd0, stall}, 64'd0);
    chk("idle_hi_old", {32'd0, hi}, {32'd0, cur_hi});
    chk("idle_lo_old", {32'd0, lo}, {32'd0, cur_lo});
    @(posedge clk); #1;
    start = 1'b0; rs_val = $urandom; rt_val = $urandom;
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      chk("run_busy", {63'd0, busy}, 64'd1);
      chk("run_stall", {63'd0, stall}, {63'd0, rd});
      chk("run_dbz", {63'd0, div_by_zero}, 64'd0);
      chk("run_hilo_hold", {hi, lo}, {cur_hi, cur_lo});
      if (second && lat > 6 && k == 4) begin
        start = 1'b1; op = $urandom_range(0, 3); rs_val = $urandom; rt_val = $urandom;
      end
      if (k == 5) start = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    chk("latency", 64'(k), 64'(lat));
    chk("res_hi", {32'd0, hi}, {32'd0, ehi});
    chk("res_lo", {32'd0, lo}, {32'd0, elo});
    chk("done_dbz", {63'd0, div_by_zero}, {63'd0, edz});
    chk("done_busy", {63'd0, busy}, 64'd0);
    chk("done_stall", {63'd0, stall}, 64'd0);
    rd_hilo = 1'b0;
    cur_hi = ehi;
    cur_lo = elo;
    @(posedge clk); #1;
    chk("post_done", {63'd0, done}, 64'd0);
    chk("post_dbz", {63'd0, div_by_zero}, 64'd0);
    chk("post_hilo", {hi, lo}, {cur_hi, cur_lo});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       pick = 32'd0;
      1:       pick = 32'd1;
      2:       pick = 32'hFFFF_FFFF;
      3:       pick = 32'h8000_0000;
      4:       pick = $urandom_range(0, 255);
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0; rd_hilo = 1'b0;
    cur_hi = '0; cur_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("multu_max_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
    chk("multu_max_lo", {32'd0, lo}, 64'h0000_0000_0000_0001);
    do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
    chk("div_neg7_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
    do_op(2'b11, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(2'b00, 32'hFFFF_FFF3, 32'h8765_4321, 1'b1, 1'b1);
    do_op(2'b01, 32'd3, 32'd5, 1'b0, 1'b0);
    do_op(2'b01, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);

    // Reset in the middle of RUN aborts the operation
    start = 1'b1; op = 2'b01; rs_val = 32'd7; rt_val = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_done", {63'd0, done}, 64'd0);
    end
    cur_hi = '0; cur_lo = '0;

    // Reset wins over a simultaneous start
    rst = 1'b1; start = 1'b1; op = 2'b00; rs_val = 32'd5; rt_val = 32'd6;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("rst_prio_busy", {63'd0, busy}, 64'd0);
    do_op(2'b01, 32'd2, 32'd3, 1'b0, 1'b0);
    chk("multu_2x3", {32'd0, lo}, 64'd6);

    for (int i = 0; i < 24; i++) begin
      do_op(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Ports SHALL be as follows.
- clk  in  1  rising-edge clock.
- rst  in  1  reset.
- start  in  1  issue request for a MULT/MULTU/DIV/DIVU from decode.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_val  in  32  multiplicand or dividend.
- rt_val  in  32  multiplier or divisor.
- rd_hilo  in  1  an MFHI/MFLO is in decode this cycle.
- busy  out  1  an operation is in flight.
- stall  out  1  freeze fetch/decode.
- done  out  1  one-cycle completion pulse.
- div_by_zero  out  1  qualifies done; divisor was zero.
- hi  out  32  HI register.
- lo  out  32  LO register.

Function
REQ-003 The state machine SHALL use states IDLE, RUN and FIN; busy SHALL equal (state != IDLE).
REQ-004 The start-accept edge (edge 0) SHALL be the edge at which state is IDLE and start is 1.
- At edge 0 the block SHALL latch op, |rs_val| and |rt_val|, and the result signs.
- Absolute values SHALL be taken only for MULT/DIV; operands SHALL pass unchanged for MULTU/DIVU.
- At edge 0 the iteration counter SHALL clear and state SHALL go to RUN.
REQ-005 start SHALL be ignored while busy=1: no relatch and no queueing.
REQ-006 Each RUN edge SHALL perform exactly one iteration.
- Multiply: shift-add, 64-bit product.
- Divide: restoring, 32-bit quotient and remainder.
REQ-007 Without the macro, RUN SHALL last exactly 32 edges (edges 1..32); state SHALL be FIN after edge 32.
REQ-008 On the FIN edge (edge 33) the block SHALL write results, pulse done for the following cycle, and return to IDLE.
- Multiply: hi:lo = signed or unsigned 64-bit product.
- Divide: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
REQ-009 Divide by zero: at FIN, hi SHALL be rs_val as latched, lo SHALL be 0xFFFFFFFF, and div_by_zero SHALL be 1 together with done; div_by_zero SHALL be 0 in every other cycle.
REQ-010 Signed DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000, with no flag.
REQ-011 stall SHALL equal rd_hilo AND busy.
- MFHI/MFLO in the cycle after done SHALL see the new hi/lo.
- start and rd_hilo both high in IDLE SHALL not stall; that read SHALL see the old hi/lo.
REQ-012 hi and lo SHALL change only at a FIN edge or on reset.

Reset
REQ-013 With rst=1 at an edge, the block SHALL set state=IDLE, busy=0, stall=0, done=0, div_by_zero=0, hi=0, lo=0, and clear the counter and internal operands.
REQ-014 Reset during RUN or FIN SHALL abort the operation: no done pulse, and hi/lo SHALL be 0.
REQ-015 rst SHALL have priority over start on the same edge.

Configuration
REQ-016 Macro MULDIV_EARLY_OUT_EN SHALL control early termination of multiplies.
- Defined: for MULT/MULTU, the block SHALL enter FIN after the RUN edge at which the remaining unshifted multiplier bits become zero.
- Defined: RUN SHALL last N = max(1, bit-length of |rt|) edges and done SHALL appear after edge N+1.
- Defined: DIV/DIVU timing SHALL be unchanged.
- Undefined: every operation SHALL use 32 RUN edges.
- Results SHALL be identical in both builds.

Verification
REQ-017 MULTU, rs=0xFFFFFFFF, rt=0xFFFFFFFF, macro off -> hi=0xFFFFFFFE, lo=0x00000001; done high in the cycle after edge 33; busy high over edges 0..33.
REQ-018 DIV, rs=0xFFFFFFF9 (-7), rt=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div_by_zero=0.
REQ-019 DIVU, rs=0x00001234, rt=0 -> hi=0x00001234, lo=0xFFFFFFFF, div_by_zero=1 for exactly the done cycle.
REQ-020 MULT with rd_hilo held high and a second start (different operands) at edge 5 -> stall=1 from edge 0 through the FIN cycle, stall=0 in the done cycle, and results match the first operands only.
REQ-021 MULTU 7*9, rst pulsed at RUN edge 10 -> next cycle busy=0, hi=lo=0; done never asserted; a new MULTU 2*3 then gives lo=6.
REQ-022 Macro on, MULTU rs=3, rt=5 -> lo=15, hi=0, done after edge 4; MULTU with rt=0 -> done after edge 2, hi=lo=0.
